// File: rtl/cla_seq_subtractor.sv
// Multi-cycle WIDTH-bit subtractor (diff = a - b - bin), 2 bits per clock through one 2-bit CLA slice.
// Optional running-decrement mode (acc_sel port) enabled by defining CLA_SUB_ACCUM_EN.
module cla_seq_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
`ifdef CLA_SUB_ACCUM_EN
    input  logic             acc_sel,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int NSLICE = WIDTH / 2;
    localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam int MSB    = WIDTH - 1;
    localparam logic [IDXW-1:0] LAST = IDXW'(NSLICE - 1);

    generate
        if (WIDTH < 2 || (WIDTH % 2) != 0) begin : g_bad_width
            $error("cla_seq_subtractor: WIDTH must be even and >= 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              accept;
    logic              last;

    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic              carry;
    logic [IDXW-1:0]   idx;
    logic [WIDTH-1:0]  minuend;

    logic [1:0]        sa;
    logic [1:0]        sb_n;
    logic [1:0]        g;
    logic [1:0]        p;
    logic [1:0]        s;
    logic              c1;
    logic              c2;

`ifdef CLA_SUB_ACCUM_EN
    assign minuend = acc_sel ? diff : a;
`else
    assign minuend = a;
`endif

    assign busy = (state == RUN);
    assign done = (state == DONE);
    assign last = (idx == LAST);

    // One 2-bit carry-lookahead slice: a + ~b + carry, carry being the inverted borrow.
    always_comb begin
        sa   = a_q[{idx, 1'b0} +: 2];
        sb_n = ~b_q[{idx, 1'b0} +: 2];
        g    = sa & sb_n;
        p    = sa ^ sb_n;
        c1   = g[0] | (p[0] & carry);
        c2   = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry);
        s    = p ^ {c1, carry};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            carry <= 1'b0;
            idx   <= '0;
            diff  <= '0;
            bout  <= 1'b0;
            ovf   <= 1'b0;
        end else if (accept) begin
            a_q   <= minuend;
            b_q   <= b;
            carry <= ~bin;
            idx   <= '0;
            diff  <= '0;
        end else if (state == RUN) begin
            diff[{idx, 1'b0} +: 2] <= s;
            carry <= c2;
            idx   <= idx + 1'b1;
            // On the last slice s[1] is the new diff MSB, so ovf sees the final result.
            if (last) begin
                bout <= ~c2;
                ovf  <= (a_q[MSB] ^ b_q[MSB]) & (s[1] ^ a_q[MSB]);
            end
        end
    end

endmodule
